sterownik_silnika_wielokanalowy: RTL and testbench
==================================================

# sterownik_silnika_wielokanalowy

Parametrised multi-channel successor of the single-motor RPM controller. Each channel owns a start/run/stop state machine, a timed start-up (rozruch) phase, a latched RPM setpoint and a rate-limited ramp that moves the working RPM toward that setpoint. Per-channel RPM values and change strobes feed the existing degree-timing, display and LED blocks.

## Interface
Parameters:
- KANALY, 2, number of independent motor channels (1..8)
- SZER_RPM, 7, RPM word width
- RPM_MAX, 100, setpoint clamp; must be less than 2^SZER_RPM
- RPM_ROZRUCHU, 10, RPM forced during start-up; must be ≤ RPM_MAX
- CZAS_ROZRUCHU, 12000000, start-up duration in clk cycles (1 s at 12 MHz)
- KROK_RAMPY, 120000, clk cycles per ±1 RPM ramp step (10 ms at 12 MHz)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  KANALY  per-channel start request; level, sampled every cycle
- stop  in  KANALY  per-channel stop request; level, sampled every cycle
- zapis_rpm  in  KANALY  per-channel one-cycle setpoint write strobe
- zadane_rpm  in  KANALY*SZER_RPM  setpoints; channel k at bits [k*SZER_RPM +: SZER_RPM]
- rpm  out  KANALY*SZER_RPM  working RPM per channel, same packing
- stan  out  KANALY*2  state per channel: 00 STOP, 01 ROZRUCH, 10 PRACA, 11 HAMOWANIE
- rozruch  out  KANALY  high while the channel is in ROZRUCH
- sygnal_zmiany_rpm  out  KANALY  one-cycle pulse in the cycle after rpm[k] changes
- gotowy  out  KANALY  high in PRACA when rpm[k] equals the setpoint

## Operation
- Channels are fully independent. All outputs are registered.
- STOP: rpm = 0. start=1 and stop=0 → ROZRUCH.
- ROZRUCH: rpm = RPM_ROZRUCHU; the start-up counter runs CZAS_ROZRUCHU cycles, then → PRACA. stop=1 → HAMOWANIE.
- PRACA: every KROK_RAMPY cycles rpm moves one step toward the setpoint (+1 or −1); no step once they are equal. stop=1 → HAMOWANIE.
- HAMOWANIE: every KROK_RAMPY cycles rpm decrements by 1. Reaching 0 → STOP. start=1 and stop=0 → PRACA; the ramp resumes from the current rpm.
- start and stop both high: stop wins in every state.
- Setpoint: zapis_rpm[k] latches zadane_rpm[k] in any state. Values above RPM_MAX are stored as RPM_MAX. A new setpoint during a ramp retargets the next step; no restart.
- Ramp counter: cleared on entry to PRACA or HAMOWANIE, then free-runs modulo KROK_RAMPY. A setpoint write does not clear it.
- Arithmetic is unsigned. rpm never wraps: it stays within 0..RPM_MAX, and RPM_ROZRUCHU applies only in ROZRUCH.
- Reset: stan = STOP, rpm = 0, setpoint = 0, all counters = 0, and rozruch, sygnal_zmiany_rpm and gotowy = 0. Reset in the middle of a ramp or start-up aborts immediately; there is no ramp-down.

## Timing
- start sampled at edge N → stan = ROZRUCH, rozruch = 1 and rpm = RPM_ROZRUCHU visible after edge N+1.
- ROZRUCH lasts exactly CZAS_ROZRUCHU cycles; stan = PRACA from edge N+1+CZAS_ROZRUCHU.
- First ramp step lands KROK_RAMPY cycles after entry to PRACA or HAMOWANIE; later steps follow every KROK_RAMPY cycles.
- sygnal_zmiany_rpm[k] pulses for 1 cycle, one cycle after each rpm[k] change, including the 0→RPM_ROZRUCHU jump.
- gotowy updates in the same cycle as rpm. A setpoint write takes effect from the next cycle.
- stop sampled at edge M → stan = HAMOWANIE after edge M+1; rpm does not change at that edge.

## Structure
- Shared package sterownik_pkg holds:
  - the state encodings STOP, ROZRUCH, PRACA, HAMOWANIE
  - the function computing counter width from CZAS_ROZRUCHU and KROK_RAMPY
- Sub-module kanal_rampy: one channel containing the state machine, setpoint register, two counters and the strobe logic. The top level is a generate loop over KANALY plus bus slicing.

## Test plan
All scenarios use KANALY=2, CZAS_ROZRUCHU=8, KROK_RAMPY=4, RPM_ROZRUCHU=10, RPM_MAX=100.
- Start-up: rst, then write setpoint 14 on ch0 and hold start[0] → rpm0 = 10 and rozruch0 = 1 for 8 cycles. Then PRACA, with rpm0 stepping 11, 12, 13, 14 at 4-cycle spacing; gotowy0 = 1 at 14; one sygnal_zmiany_rpm0 pulse per change.
- Clamp and retarget: in PRACA at rpm 14, write setpoint 120 → ramp heads to 100. Write 12 mid-ramp at rpm 16 → next step is 15, settling at 12.
- Stop and resume: stop[0] at rpm 14 → HAMOWANIE, −1 every 4 cycles. start[0] at rpm 11 → PRACA, ramps back to 14. Stop held to 0 → STOP.
- Conflicts: start and stop high together in STOP → stays STOP, rpm = 0. Stop during ROZRUCH → HAMOWANIE from rpm 10 down to 0.
- Independence: ch1 started 3 cycles after ch0 with setpoint 20 → ch1 timing offset by exactly 3 cycles; ch0 unaffected.
- Reset mid-ramp: rst during PRACA at rpm 13 → next cycle all outputs 0, stan = STOP, setpoint cleared.

Source files
------------

// File: rtl/sterownik_pkg.sv
// Shared definitions for the multi-channel motor controller: channel state
// encoding and the counter width helper.
package sterownik_pkg;

   typedef enum logic [1:0] {
      Stop      = 2'b00,
      Rozruch   = 2'b01,
      Praca     = 2'b10,
      Hamowanie = 2'b11
   } stan_e;

   // Wide enough to hold the largest terminal count of either timer.
   function automatic int unsigned szer_licznika(input int unsigned czas,
                                                 input int unsigned krok);
      int unsigned m;
      m = (czas > krok) ? czas : krok;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/kanal_rampy.sv
// One motor channel: start/run/stop FSM, timed start-up, clamped setpoint
// register and a rate-limited ramp of the working RPM.
module kanal_rampy
   import sterownik_pkg::*;
#(
   parameter int unsigned SZER_RPM      = 7,
   parameter int unsigned RPM_MAX       = 100,
   parameter int unsigned RPM_ROZRUCHU  = 10,
   parameter int unsigned CZAS_ROZRUCHU = 12000000,
   parameter int unsigned KROK_RAMPY    = 120000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                zapis_rpm,
   input  logic [SZER_RPM-1:0] zadane_rpm,
   output logic [SZER_RPM-1:0] rpm,
   output logic [1:0]          stan,
   output logic                rozruch,
   output logic                sygnal_zmiany_rpm,
   output logic                gotowy
);

   localparam int unsigned SzerLicz = szer_licznika(CZAS_ROZRUCHU, KROK_RAMPY);
   localparam logic [SZER_RPM-1:0] RpmMax      = SZER_RPM'(RPM_MAX);
   localparam logic [SZER_RPM-1:0] RpmRozruchu = SZER_RPM'(RPM_ROZRUCHU);
   localparam logic [SZER_RPM-1:0] RpmJeden    = SZER_RPM'(1);
   localparam logic [SzerLicz-1:0] KoniecRozruchu = SzerLicz'(CZAS_ROZRUCHU - 1);
   localparam logic [SzerLicz-1:0] KoniecKroku    = SzerLicz'(KROK_RAMPY - 1);

   stan_e               stan_q, stan_d;
   logic [SZER_RPM-1:0] rpm_q, rpm_d, rpm_poprz_q, zad_q, zad_d;
   logic [SzerLicz-1:0] licz_roz_q, licz_roz_d, licz_rampy_q, licz_rampy_d;
   logic                start_q, stop_q, rozruch_q, zmiana_q, gotowy_q;
   logic                uruchom, krok;

   // start/stop act one edge after they are sampled; stop always dominates.
   assign uruchom = start_q & ~stop_q;
   assign krok    = (licz_rampy_q == KoniecKroku);

   always_comb begin
      stan_d       = stan_q;
      rpm_d        = rpm_q;
      licz_roz_d   = licz_roz_q;
      licz_rampy_d = krok ? '0 : licz_rampy_q + 1'b1;
      zad_d        = zad_q;
      if (zapis_rpm) begin
         zad_d = (zadane_rpm > RpmMax) ? RpmMax : zadane_rpm;
      end
      unique case (stan_q)
         Stop: begin
            if (uruchom) begin
               stan_d     = Rozruch;
               rpm_d      = RpmRozruchu;
               licz_roz_d = '0;
            end
         end
         Rozruch: begin
            if (stop_q) begin
               stan_d       = Hamowanie;
               licz_rampy_d = '0;
            end else if (licz_roz_q == KoniecRozruchu) begin
               stan_d       = Praca;
               licz_rampy_d = '0;
            end else begin
               licz_roz_d = licz_roz_q + 1'b1;
            end
         end
         Praca: begin
            if (stop_q) begin
               stan_d       = Hamowanie;
               licz_rampy_d = '0;
            end else if (krok) begin
               if (rpm_q < zad_q) begin
                  rpm_d = rpm_q + 1'b1;
               end else if (rpm_q > zad_q) begin
                  rpm_d = rpm_q - 1'b1;
               end
            end
         end
         Hamowanie: begin
            if (uruchom) begin
               stan_d       = Praca;
               licz_rampy_d = '0;
            end else if (rpm_q == '0) begin
               stan_d = Stop;
            end else if (krok) begin
               rpm_d = rpm_q - 1'b1;
               if (rpm_q == RpmJeden) begin
                  stan_d = Stop;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stan_q       <= Stop;
         rpm_q        <= '0;
         rpm_poprz_q  <= '0;
         zad_q        <= '0;
         licz_roz_q   <= '0;
         licz_rampy_q <= '0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
         rozruch_q    <= 1'b0;
         zmiana_q     <= 1'b0;
         gotowy_q     <= 1'b0;
      end else begin
         stan_q       <= stan_d;
         rpm_q        <= rpm_d;
         rpm_poprz_q  <= rpm_q;
         zad_q        <= zad_d;
         licz_roz_q   <= licz_roz_d;
         licz_rampy_q <= licz_rampy_d;
         start_q      <= start;
         stop_q       <= stop;
         rozruch_q    <= (stan_d == Rozruch);
         // Compares the previous two rpm values, so the pulse trails the change by a cycle.
         zmiana_q     <= (rpm_q != rpm_poprz_q);
         gotowy_q     <= (stan_d == Praca) && (rpm_d == zad_d);
      end
   end

   assign rpm               = rpm_q;
   assign stan              = stan_q;
   assign rozruch           = rozruch_q;
   assign sygnal_zmiany_rpm = zmiana_q;
   assign gotowy            = gotowy_q;

endmodule

// File: rtl/sterownik_silnika_wielokanalowy.sv
// Multi-channel RPM controller: KANALY independent ramp channels sharing one
// clock, with per-channel fields packed into flat buses.
module sterownik_silnika_wielokanalowy #(
   parameter int unsigned KANALY        = 2,
   parameter int unsigned SZER_RPM      = 7,
   parameter int unsigned RPM_MAX       = 100,
   parameter int unsigned RPM_ROZRUCHU  = 10,
   parameter int unsigned CZAS_ROZRUCHU = 12000000,
   parameter int unsigned KROK_RAMPY    = 120000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KANALY-1:0]            start,
   input  logic [KANALY-1:0]            stop,
   input  logic [KANALY-1:0]            zapis_rpm,
   input  logic [KANALY*SZER_RPM-1:0]   zadane_rpm,
   output logic [KANALY*SZER_RPM-1:0]   rpm,
   output logic [KANALY*2-1:0]          stan,
   output logic [KANALY-1:0]            rozruch,
   output logic [KANALY-1:0]            sygnal_zmiany_rpm,
   output logic [KANALY-1:0]            gotowy
);

   for (genvar k = 0; k < KANALY; k++) begin : g_kanal
      kanal_rampy #(
         .SZER_RPM      (SZER_RPM),
         .RPM_MAX       (RPM_MAX),
         .RPM_ROZRUCHU  (RPM_ROZRUCHU),
         .CZAS_ROZRUCHU (CZAS_ROZRUCHU),
         .KROK_RAMPY    (KROK_RAMPY)
      ) u_kanal (
         .clk               (clk),
         .rst               (rst),
         .start             (start[k]),
         .stop              (stop[k]),
         .zapis_rpm         (zapis_rpm[k]),
         .zadane_rpm        (zadane_rpm[k*SZER_RPM +: SZER_RPM]),
         .rpm               (rpm[k*SZER_RPM +: SZER_RPM]),
         .stan              (stan[k*2 +: 2]),
         .rozruch           (rozruch[k]),
         .sygnal_zmiany_rpm (sygnal_zmiany_rpm[k]),
         .gotowy            (gotowy[k])
      );
   end

endmodule

// File: tb/tb_sterownik_silnika_wielokanalowy.sv
// Bench for the multi-channel RPM controller: a directed vector table, hand
// sequences for timing corners, and random stimulus against a reference model.
module tb_sterownik_silnika_wielokanalowy;

   localparam int K    = 2;
   localparam int W    = 7;
   localparam int CZAS = 8;
   localparam int KROK = 4;
   localparam int RMAX = 100;
   localparam int RROZ = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [K-1:0]   start, stop, zapis;
   logic [K*W-1:0] zadane, rpm;
   logic [K*2-1:0] stan;
   logic [K-1:0]   rozruch, sig, gotowy;

   always #5 clk = ~clk;

   sterownik_silnika_wielokanalowy #(
      .KANALY        (K),
      .SZER_RPM      (W),
      .RPM_MAX       (RMAX),
      .RPM_ROZRUCHU  (RROZ),
      .CZAS_ROZRUCHU (CZAS),
      .KROK_RAMPY    (KROK)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .stop              (stop),
      .zapis_rpm         (zapis),
      .zadane_rpm        (zadane),
      .rpm               (rpm),
      .stan              (stan),
      .rozruch           (rozruch),
      .sygnal_zmiany_rpm (sig),
      .gotowy            (gotowy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: phase plus time spent in it, per channel.
   // Phases: 0 stop, 1 start-up, 2 run, 3 braking.
   int m_faza[K], m_rpm[K], m_zad[K], m_prev[K], m_t[K];
   bit m_sig[K], m_got[K], m_s[K], m_p[K];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < K; k++) begin
         int old_r, nz, nf, nr;
         if (rst) begin
            m_faza[k] = 0; m_rpm[k] = 0; m_zad[k] = 0; m_prev[k] = 0; m_t[k] = 0;
            m_sig[k] = 0; m_got[k] = 0; m_s[k] = 0; m_p[k] = 0;
            continue;
         end
         old_r = m_rpm[k];
         nz = m_zad[k];
         if (zapis[k]) nz = (int'(zadane[k*W +: W]) > RMAX) ? RMAX : int'(zadane[k*W +: W]);
         nf = m_faza[k];
         nr = old_r;
         m_t[k]++;
         case (m_faza[k])
            0: if (m_s[k] && !m_p[k]) begin nf = 1; nr = RROZ; m_t[k] = 0; end
            1: begin
               if (m_p[k]) begin nf = 3; m_t[k] = 0; end
               else if (m_t[k] == CZAS) begin nf = 2; m_t[k] = 0; end
            end
            2: begin
               if (m_p[k]) begin nf = 3; m_t[k] = 0; end
               else if (m_t[k] % KROK == 0) begin
                  if (old_r < m_zad[k]) nr = old_r + 1;
                  else if (old_r > m_zad[k]) nr = old_r - 1;
               end
            end
            default: begin
               if (m_s[k] && !m_p[k]) begin nf = 2; m_t[k] = 0; end
               else if (old_r == 0) nf = 0;
               else if (m_t[k] % KROK == 0) begin
                  nr = old_r - 1;
                  if (nr == 0) nf = 0;
               end
            end
         endcase
         m_sig[k]  = (old_r != m_prev[k]);
         m_prev[k] = old_r;
         m_rpm[k]  = nr;
         m_faza[k] = nf;
         m_zad[k]  = nz;
         m_got[k]  = (nf == 2) && (nr == nz);
         m_s[k]    = start[k];
         m_p[k]    = stop[k];
      end
   endtask

   task automatic check_model();
      logic [K*W-1:0] er;
      logic [K*2-1:0] es;
      logic [K-1:0]   eroz, esig, egot;
      for (int k = 0; k < K; k++) begin
         er[k*W +: W] = W'(m_rpm[k]);
         es[k*2 +: 2] = 2'(m_faza[k]);
         eroz[k]      = (m_faza[k] == 1);
         esig[k]      = m_sig[k];
         egot[k]      = m_got[k];
      end
      check("model_rpm", 32'(rpm), 32'(er));
      check("model_stan", 32'(stan), 32'(es));
      check("model_rozruch", 32'(rozruch), 32'(eroz));
      check("model_zmiana", 32'(sig), 32'(esig));
      check("model_gotowy", 32'(gotowy), 32'(egot));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   typedef struct {
      int   n;
      logic st, sp, zp;
      int   zad0;
      int   e_stan, e_rpm;
      logic e_got;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t v(int n, logic st, logic sp, logic zp, int zad0,
                              int e_stan, int e_rpm, logic e_got);
      vec_t r;
      r.n = n; r.st = st; r.sp = sp; r.zp = zp; r.zad0 = zad0;
      r.e_stan = e_stan; r.e_rpm = e_rpm; r.e_got = e_got;
      return r;
   endfunction

   initial begin
      rst = 1'b1; start = '0; stop = '0; zapis = '0; zadane = '0;
      tick();
      tick();
      check("reset_rpm", 32'(rpm), 0);
      check("reset_stan", 32'(stan), 0);
      check("reset_flags", 32'({rozruch, sig, gotowy}), 0);
      rst = 1'b0;

      // Channel 0 walk-through; edge numbers count from the first vector.
      tab.push_back(v(1,  1, 0, 1, 14,  0, 0,  0));  // e1
      tab.push_back(v(1,  1, 0, 0, 0,   1, 10, 0));  // e2 start-up
      tab.push_back(v(7,  1, 0, 0, 0,   1, 10, 0));  // e9
      tab.push_back(v(1,  1, 0, 0, 0,   2, 10, 0));  // e10 run
      tab.push_back(v(4,  1, 0, 0, 0,   2, 11, 0));  // e14
      tab.push_back(v(12, 1, 0, 0, 0,   2, 14, 1));  // e26
      tab.push_back(v(1,  1, 0, 1, 120, 2, 14, 0));  // e27 clamp to 100
      tab.push_back(v(7,  1, 0, 0, 0,   2, 16, 0));  // e34
      tab.push_back(v(1,  1, 0, 1, 12,  2, 16, 0));  // e35 retarget
      tab.push_back(v(3,  1, 0, 0, 0,   2, 15, 0));  // e38
      tab.push_back(v(12, 1, 0, 0, 0,   2, 12, 1));  // e50
      tab.push_back(v(8,  1, 0, 0, 0,   2, 12, 1));  // e58
      tab.push_back(v(1,  1, 0, 1, 14,  2, 12, 0));  // e59
      tab.push_back(v(7,  1, 0, 0, 0,   2, 14, 1));  // e66
      tab.push_back(v(2,  0, 1, 0, 0,   3, 14, 0));  // e68 braking
      tab.push_back(v(12, 0, 0, 0, 0,   3, 11, 0));  // e80
      tab.push_back(v(2,  1, 0, 0, 0,   2, 11, 0));  // e82 resume
      tab.push_back(v(12, 1, 0, 0, 0,   2, 14, 1));  // e94
      tab.push_back(v(2,  0, 1, 0, 0,   3, 14, 0));  // e96
      tab.push_back(v(55, 0, 1, 0, 0,   3, 1,  0));  // e151
      tab.push_back(v(1,  0, 1, 0, 0,   0, 0,  0));  // e152 stopped
      tab.push_back(v(5,  1, 1, 0, 0,   0, 0,  0));  // e157 stop wins
      tab.push_back(v(2,  1, 0, 0, 0,   1, 10, 0));  // e159
      tab.push_back(v(2,  0, 1, 0, 0,   3, 10, 0));  // e161 stop in start-up
      tab.push_back(v(39, 0, 0, 0, 0,   3, 1,  0));  // e200
      tab.push_back(v(1,  0, 0, 0, 0,   0, 0,  0));  // e201

      foreach (tab[i]) begin
         for (int c = 0; c < tab[i].n; c++) begin
            start     = {1'b0, tab[i].st};
            stop      = {1'b0, tab[i].sp};
            zapis     = {1'b0, tab[i].zp && (c == 0)};
            zadane    = {7'd0, W'(tab[i].zad0)};
            tick();
         end
         check($sformatf("vec%0d_stan", i), 32'(stan[1:0]), 32'(tab[i].e_stan));
         check($sformatf("vec%0d_rpm", i), 32'(rpm[W-1:0]), 32'(tab[i].e_rpm));
         check($sformatf("vec%0d_gotowy", i), 32'(gotowy[0]), 32'(tab[i].e_got));
      end

      // Independence: ch1 started three cycles after ch0.
      start = '0; stop = '0; zapis = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         start  = {logic'(e >= 4), 1'b1};
         zapis  = (e == 1) ? 2'b11 : 2'b00;
         zadane = {7'd20, 7'd14};
         tick();
         case (e)
            4:  check("ind_ch1_stop", 32'(stan[3:2]), 0);
            5:  check("ind_ch1_rozruch", 32'(stan[3:2]), 1);
            10: check("ind_stan_pair", 32'(stan), 32'({2'd1, 2'd2}));
            12: check("ind_ch1_still_rozruch", 32'(stan[3:2]), 1);
            13: check("ind_ch1_praca", 32'(stan[3:2]), 2);
            14: check("ind_rpm_pair", 32'(rpm), 32'({7'd10, 7'd11}));
            17: check("ind_ch1_step", 32'(rpm[2*W-1:W]), 11);
            22: check("ind_ch0_13", 32'(rpm[W-1:0]), 13);
            default: ;
         endcase
      end

      // Reset mid-ramp, then confirm the setpoint was cleared.
      rst = 1'b1; zapis = '0; start = '0;
      tick();
      check("rst_rpm", 32'(rpm), 0);
      check("rst_stan", 32'(stan), 0);
      check("rst_flags", 32'({rozruch, sig, gotowy}), 0);
      rst = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         start = 2'b01;
         tick();
         if (e == 2)  check("rst_restart_rozruch", 32'(stan[1:0]), 1);
         if (e == 10) check("rst_restart_praca", 32'(stan[1:0]), 2);
         if (e == 14) check("rst_zad_cleared", 32'(rpm[W-1:0]), 9);
      end

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < K; k++) begin
            if ($urandom_range(15) == 0) start[k] = ~start[k];
            if ($urandom_range(19) == 0) stop[k]  = ~stop[k];
            zapis[k] = ($urandom_range(9) == 0);
            zadane[k*W +: W] = W'($urandom);
         end
         rst = ($urandom_range(599) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
